spi_pattern_source: RTL

Parametrised SPI-slave test-pattern generator for the LA104 FPGA mini designs. After the host drops SSEL, the block receives an 8-bit command byte on MOSI, then streams WIDTH-bit words on MISO (up/down counter, LFSR or walking-one), separated by an optional run of Hi-Z marker bit slots. It sits directly on the SPI pins and is used to validate the analyser's SPI decoder and word-framing logic.

---
 rtl/spi_pattern_source.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spi_pattern_source.sv
// SPI-slave test-pattern source: takes one command byte on MOSI, then streams
// counter / LFSR / walking-one words on MISO with optional Hi-Z gap slots.
module spi_pattern_source #(
    parameter int              WIDTH       = 8,
    parameter int              GAP_BITS    = 1,
    parameter bit              MSB_FIRST   = 1'b1,
    parameter logic [WIDTH-1:0] LFSR_TAPS  = 8'hB8,
    parameter int              SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SSEL,
    input  logic MOSI,
    input  logic SCK,
    inout  wire  MISO
);

    localparam int CNT_W = ($clog2(WIDTH) > 3) ? $clog2(WIDTH) : 3;

    typedef enum logic [1:0] {IDLE, CMD, DATA, GAP} state_t;

    // Synchroniser chains carry one extra history flop so edges come from the
    // two oldest stages.
    logic [SYNC_STAGES:0]   ssel_sync;
    logic [SYNC_STAGES:0]   sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic ssel_s, ssel_fall, sck_rise, sck_fall, mosi_s;

    state_t           state, state_nxt;
    logic [7:0]       cmd, cmd_nxt;
    logic [1:0]       mode, mode_nxt;
    logic             nogap, nogap_nxt;
    logic [WIDTH-1:0] word, word_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] bitcnt, bitcnt_nxt;
    logic [2:0]       gapcnt, gapcnt_nxt;
    logic             tx_en, tx_bit;
    logic [7:0]       cmd_sh;
    logic [WIDTH-1:0] word_next;

    function automatic logic [WIDTH-1:0] seed_word(input logic [1:0] m);
        logic [WIDTH-1:0] s;
        s = (m == 2'b01) ? '1 : '0;
        if (m == 2'b10 || m == 2'b11)
            s = WIDTH'(1);
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m,
                                                   input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] n;
        case (m)
            2'b00:   n = w + 1'b1;
            2'b01:   n = w - 1'b1;
            2'b10: begin
                n = {w[WIDTH-2:0], ^(w & LFSR_TAPS)};
                // The all-zero state would lock the LFSR up.
                if (n == '0)
                    n = WIDTH'(1);
            end
            default: n = {w[WIDTH-2:0], w[WIDTH-1]};
        endcase
        return n;
    endfunction

    assign ssel_s    = ssel_sync[SYNC_STAGES-1];
    assign ssel_fall = ~ssel_sync[SYNC_STAGES-1] & ssel_sync[SYNC_STAGES];
    assign sck_rise  = sck_sync[SYNC_STAGES-1] & ~sck_sync[SYNC_STAGES];
    assign sck_fall  = ~sck_sync[SYNC_STAGES-1] & sck_sync[SYNC_STAGES];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cmd_sh    = {cmd[6:0], mosi_s};
    assign word_next = next_word(mode, word);

    always_comb begin
        state_nxt  = state;
        cmd_nxt    = cmd;
        mode_nxt   = mode;
        nogap_nxt  = nogap;
        word_nxt   = word;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        gapcnt_nxt = gapcnt;
        if (ssel_s) begin
            state_nxt = IDLE;
        end else if (ssel_fall) begin
            cmd_nxt    = '0;
            bitcnt_nxt = '0;
            state_nxt  = CMD;
        end else begin
            case (state)
                CMD: if (sck_rise) begin
                    cmd_nxt = cmd_sh;
                    if (bitcnt == CNT_W'(7)) begin
                        mode_nxt   = cmd_sh[1:0];
                        nogap_nxt  = cmd_sh[2];
                        word_nxt   = seed_word(cmd_sh[1:0]);
                        shreg_nxt  = seed_word(cmd_sh[1:0]);
                        bitcnt_nxt = '0;
                        state_nxt  = DATA;
                    end else begin
                        bitcnt_nxt = bitcnt + 1'b1;
                    end
                end
                DATA: if (sck_fall) begin
                    shreg_nxt  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                           : {1'b0, shreg[WIDTH-1:1]};
                    bitcnt_nxt = bitcnt + 1'b1;
                    if (bitcnt == CNT_W'(WIDTH - 1)) begin
                        if (GAP_BITS == 0 || nogap) begin
                            word_nxt   = word_next;
                            shreg_nxt  = word_next;
                            bitcnt_nxt = '0;
                        end else begin
                            gapcnt_nxt = 3'(GAP_BITS);
                            state_nxt  = GAP;
                        end
                    end
                end
                GAP: if (sck_fall) begin
                    gapcnt_nxt = gapcnt - 1'b1;
                    if (gapcnt == 3'd1) begin
                        word_nxt   = word_next;
                        shreg_nxt  = word_next;
                        bitcnt_nxt = '0;
                        state_nxt  = DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssel_sync <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            state     <= IDLE;
            cmd       <= '0;
            mode      <= '0;
            nogap     <= 1'b0;
            word      <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            gapcnt    <= '0;
            tx_en     <= 1'b0;
            tx_bit    <= 1'b0;
        end else begin
            ssel_sync <= {ssel_sync[SYNC_STAGES-1:0], SSEL};
            sck_sync  <= {sck_sync[SYNC_STAGES-1:0], SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            state     <= state_nxt;
            cmd       <= cmd_nxt;
            mode      <= mode_nxt;
            nogap     <= nogap_nxt;
            word      <= word_nxt;
            shreg     <= shreg_nxt;
            bitcnt    <= bitcnt_nxt;
            gapcnt    <= gapcnt_nxt;
            // Output stage: pin drivers follow the registered state one clk later.
            tx_en     <= (state == DATA);
            tx_bit    <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        end
    end

    assign MISO = tx_en ? tx_bit : 1'bz;

endmodule
